// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the single-cycle core: sequential
// fetch, branch/jump redirect, trap entry/return, saved EPC and issue counting.
module pc_sequencer #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
    parameter int                INC          = 4,
    parameter int                CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap,
    input  logic             mret,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic [XLEN-1:0]  epc,
    output logic             misaligned,
    output logic             in_trap,
    output logic [CNT_W-1:0] issue_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_e;

    // INC is a power of two, so its low bits form the alignment mask.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             advance;
    logic             target_mis;

    assign target_mis = (redirect_target & ALIGN_MASK) != '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        advance = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, TRAP: begin
                advance = 1'b1;
                if (trap) begin
                    pc_d    = TRAP_VECTOR;
                    epc_d   = pc_q;
                    state_d = TRAP;
                end else if (mret) begin
                    pc_d    = epc_q;
                    state_d = RUN;
                end else if (redirect_valid && target_mis) begin
                    pc_d    = TRAP_VECTOR;
                    epc_d   = pc_q;
                    state_d = TRAP;
                    mis_d   = 1'b1;
                end else if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(INC);
                end else begin
                    advance = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        cnt_d = advance ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = (state_q != BOOT);
    assign epc         = epc_q;
    assign misaligned  = mis_q;
    assign in_trap     = (state_q == TRAP);
    assign issue_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected post-edge state
// into a queue, a monitor pops and compares one entry after each rising edge.
module tb_pc_sequencer;

    localparam int EW = 99;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        mret;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] epc;
    logic        misaligned;
    logic        in_trap;
    logic [31:0] issue_count;
    logic [1:0]  state;

    logic        rst4;
    logic [31:0] pc4;
    logic        pc_valid4;
    logic [31:0] epc4;
    logic        mis4;
    logic        in_trap4;
    logic [3:0]  cnt4;
    logic [1:0]  state4;

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int vec_idx  = 0;

    pc_sequencer u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .mret            (mret),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .epc             (epc),
        .misaligned      (misaligned),
        .in_trap         (in_trap),
        .issue_count     (issue_count),
        .state           (state)
    );

    pc_sequencer #(.CNT_W(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst4),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .trap            (1'b0),
        .mret            (1'b0),
        .pc              (pc4),
        .pc_valid        (pc_valid4),
        .epc             (epc4),
        .misaligned      (mis4),
        .in_trap         (in_trap4),
        .issue_count     (cnt4),
        .state           (state4)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Driver: call at a falling edge; one call covers exactly one rising edge.
    task automatic step(input logic s, input logic rv, input logic [31:0] rt,
                        input logic tr, input logic mr,
                        input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic e_mis, input logic e_trap, input logic e_valid,
                        input logic [31:0] e_cnt);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        trap            = tr;
        mret            = mr;
        exp_q.push_back({e_pc, e_epc, e_mis, e_trap, e_valid, e_cnt});
        @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec_idx++;
                check($sformatf("v%0d_pc", vec_idx), pc, e[98:67]);
                check($sformatf("v%0d_epc", vec_idx), epc, e[66:35]);
                check($sformatf("v%0d_misaligned", vec_idx), {31'b0, misaligned}, {31'b0, e[34]});
                check($sformatf("v%0d_in_trap", vec_idx), {31'b0, in_trap}, {31'b0, e[33]});
                check($sformatf("v%0d_pc_valid", vec_idx), {31'b0, pc_valid}, {31'b0, e[32]});
                check($sformatf("v%0d_issue_count", vec_idx), issue_count, e[31:0]);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_epc"}, epc, 32'h0);
        check({tag, "_pc_valid"}, {31'b0, pc_valid}, 32'h0);
        check({tag, "_misaligned"}, {31'b0, misaligned}, 32'h0);
        check({tag, "_in_trap"}, {31'b0, in_trap}, 32'h0);
        check({tag, "_issue_count"}, issue_count, 32'h0);
        check({tag, "_state"}, {30'b0, state}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap = 1'b0; mret = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        //   stall rv  target        trap mret   pc            epc          mis trp vld cnt
        step(0, 0, 32'h0,        0, 0,  32'h0,        32'h0,   0, 0, 1, 0);  // BOOT -> RUN
        step(0, 0, 32'h0,        0, 0,  32'h4,        32'h0,   0, 0, 1, 1);
        step(0, 0, 32'h0,        0, 0,  32'h8,        32'h0,   0, 0, 1, 2);
        step(0, 0, 32'h0,        0, 0,  32'hC,        32'h0,   0, 0, 1, 3);
        step(1, 0, 32'h0,        0, 0,  32'hC,        32'h0,   0, 0, 1, 3);
        step(1, 0, 32'h0,        0, 0,  32'hC,        32'h0,   0, 0, 1, 3);
        step(1, 0, 32'h0,        0, 0,  32'hC,        32'h0,   0, 0, 1, 3);
        step(0, 0, 32'h0,        0, 0,  32'h10,       32'h0,   0, 0, 1, 4);
        step(1, 1, 32'h40,       0, 0,  32'h40,       32'h0,   0, 0, 1, 5);  // redirect beats stall
        step(0, 0, 32'h0,        0, 0,  32'h44,       32'h0,   0, 0, 1, 6);
        step(0, 1, 32'h52,       0, 0,  32'h100,      32'h44,  1, 1, 1, 7);  // misaligned target
        step(0, 0, 32'h0,        0, 0,  32'h104,      32'h44,  0, 1, 1, 8);
        step(0, 0, 32'h0,        0, 1,  32'h44,       32'h44,  0, 0, 1, 9);  // mret
        step(0, 0, 32'h0,        0, 1,  32'h44,       32'h44,  0, 0, 1, 10); // mret in RUN
        step(0, 1, 32'h20,       0, 0,  32'h20,       32'h44,  0, 0, 1, 11);
        step(0, 1, 32'h80,       1, 0,  32'h100,      32'h20,  0, 1, 1, 12); // trap beats redirect
        step(1, 0, 32'h0,        1, 0,  32'h100,      32'h100, 0, 1, 1, 13); // trap while in TRAP
        step(1, 1, 32'h3,        0, 0,  32'h100,      32'h100, 1, 1, 1, 14);

        rst = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap = 1'b0; mret = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        rst = 1'b0;

        step(0, 1, 32'h80,       1, 1,  32'h0,        32'h0,   0, 0, 1, 0);  // BOOT ignores inputs
        step(0, 1, 32'hFFFF_FFFC,0, 0,  32'hFFFF_FFFC,32'h0,   0, 0, 1, 1);
        step(0, 0, 32'h0,        0, 0,  32'h0,        32'h0,   0, 0, 1, 2);  // pc wraps
        step(0, 0, 32'h0,        0, 0,  32'h4,        32'h0,   0, 0, 1, 3);

        rst4 = 1'b0;
        repeat (16) @(negedge clk);
        check("cnt4_max", {28'b0, cnt4}, 32'd15);
        check("cnt4_pc_before_wrap", pc4, 32'h3C);
        @(negedge clk);
        check("cnt4_wrap", {28'b0, cnt4}, 32'd0);
        check("cnt4_pc_after_wrap", pc4, 32'h40);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
